// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (seq_div_n) and its
// single-iteration step (div_step).
//   state_t     : divider FSM states IDLE / RUN / DONE
//   div_cnt_w() : iteration counter width for an N-bit divide, clog2(N)
//   DIV_ZERO_Q  : quotient returned on divide by zero (all ones, sliced to N)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter runs 0..N-1, so clog2(N) bits are enough (N >= 2 gives >= 1).
    function automatic int div_cnt_w(input int n);
        return $clog2(n);
    endfunction

    localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The partial remainder is
// shifted left by one with the next dividend bit appended, forming an (N+1)-bit
// trial value; the divisor is subtracted when it fits.
// Ports:
//   rem_in  [N-1:0] : partial remainder before this step (always < b)
//   dvd_bit         : next dividend bit, MSB first
//   b       [N-1:0] : divisor (magnitude)
//   rem_out [N-1:0] : partial remainder after this step
//   q_bit           : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_in,
    input  logic         dvd_bit,
    input  logic [N-1:0] b,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] trial;

    always_comb begin
        trial = {rem_in, dvd_bit};
        q_bit = (trial >= {1'b0, b});
        // The true difference is < b, so it fits in N bits; computing it
        // modulo 2^N on the low bits gives the exact result.
        if (q_bit) begin
            rem_out = trial[N-1:0] - b;
        end else begin
            rem_out = trial[N-1:0];
        end
    end

endmodule

// File: rtl/seq_div_n.sv
// -----------------------------------------------------------------------------
// seq_div_n
// Multi-cycle restoring divider: quotient and remainder of two N-bit operands
// with a valid/ready handshake on both sides. One restoring step per clock,
// MSB first, using a single shared div_step instance.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : is_signed port exists; signed ops divide magnitudes and fix
//               the signs when the result registers are written (quotient
//               truncates toward zero, remainder follows the dividend sign).
//   undefined : unsigned only, no is_signed port.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_ready only in IDLE, 0 in reset)
//   a, b               : dividend, divisor
//   is_signed          : two's-complement op (DIV_SIGNED_EN only)
//   out_valid/out_ready: result handshake (out_valid in DONE)
//   q, r, div_by_zero  : registered results, stable while out_valid is high
//   busy               : high in RUN or DONE
// -----------------------------------------------------------------------------
module seq_div_n
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic         is_signed,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int CNT_W = div_cnt_w(N);

    state_t state_q, state_d;

    // Dividend shift register: dividend bits leave at the MSB while quotient
    // bits enter at the LSB, so after N steps it holds the quotient.
    logic [N-1:0]     dvd_q, dvd_d;
    logic [N-1:0]     dvs_q, dvs_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [N-1:0]     a_mag, b_mag;
    logic [N-1:0]     quot_fin, rem_fin;
    logic [N-1:0]     q_fix, r_fix;
    logic [N-1:0]     step_rem;
    logic             step_q;
    logic             accept;
    logic             last_step;

`ifdef DIV_SIGNED_EN
    logic             a_neg, b_neg;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[N-1]),
        .b       (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Operand conditioning and final sign correction.
    always_comb begin
        quot_fin = {dvd_q[N-2:0], step_q};
        rem_fin  = step_rem;
`ifdef DIV_SIGNED_EN
        a_neg = is_signed & a[N-1];
        b_neg = is_signed & b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        // Most-negative / -1 needs no special case: the magnitude quotient
        // 2^(N-1) with a positive sign already equals a.
        q_fix = qneg_q ? -quot_fin : quot_fin;
        r_fix = rneg_q ? -rem_fin : rem_fin;
`else
        a_mag = a;
        b_mag = b;
        q_fix = quot_fin;
        r_fix = rem_fin;
`endif
    end

    // Datapath next-state.
    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        r_d    = r_q;
        dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    rem_d = '0;
                    cnt_d = '0;
                    dbz_d = (b == '0);
`ifdef DIV_SIGNED_EN
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
`endif
                    if (b == '0) begin
                        q_d = DIV_ZERO_Q[N-1:0];
                        r_d = a;
                    end
                end
            end
            RUN: begin
                dvd_d = quot_fin;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    q_d = q_fix;
                    r_d = r_fix;
                end
            end
            default: begin
            end
        endcase
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: all decoded from the state register; in_ready is also
    // forced low while reset is held.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

    // State and visible result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working registers are always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        rem_q  <= rem_d;
        cnt_q  <= cnt_d;
`ifdef DIV_SIGNED_EN
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
`endif
    end

endmodule
